reset_sequencer: RTL and testbench

//   Power-up reset sequencer for the clk_25 domain. Replaces the single global

---
 rtl/reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: releases per-stage resets in order with a ready
// handshake per stage, a software-requested re-sequence and sticky timeout fault.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned STAGE_DELAY   = 16,
  parameter int unsigned READY_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 8,
  localparam int unsigned IDX_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_25,
  input  logic                  sys_reset_n,
  input  logic                  soft_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_up,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      fail_stage
);

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_GAP      = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                  all_up_q, all_up_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]      fail_stage_q, fail_stage_d;
  logic [IDX_W-1:0]      idx_inc;

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_reset_d = stage_reset_q;
    all_up_d      = 1'b0;
    busy_d        = 1'b1;
    timeout_err_d = timeout_err_q;
    fail_stage_d  = fail_stage_q;

    case (state_q)
      ST_ASSERT: begin
        stage_reset_d = '1;
        if (cnt_q == DELAY_LAST) begin
          stage_reset_d[idx_q] = 1'b0;
          cnt_d                = '0;
          state_d              = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_RDY: begin
        if (stage_ready[idx_q]) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_RUN;
            all_up_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_FAULT;
          timeout_err_d = 1'b1;
          fail_stage_d  = idx_q;
          stage_reset_d = '1;
          busy_d        = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == DELAY_LAST) begin
          idx_d                  = idx_inc;
          stage_reset_d[idx_inc] = 1'b0;
          cnt_d                  = '0;
          state_d                = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        all_up_d = 1'b1;
        busy_d   = 1'b0;
        if (soft_req) begin
          stage_reset_d[LAST_IDX] = 1'b1;
          all_up_d                = 1'b0;
          busy_d                  = 1'b1;
          idx_d                   = LAST_IDX - IDX_W'(1);
          state_d                 = ST_SHUTDOWN;
        end
      end

      // Re-assert from the top stage down, one stage per cycle.
      ST_SHUTDOWN: begin
        stage_reset_d[idx_q] = 1'b1;
        if (idx_q == '0) begin
          cnt_d   = '0;
          state_d = ST_ASSERT;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      ST_FAULT: begin
        stage_reset_d = '1;
        busy_d        = 1'b0;
        if (soft_req) begin
          timeout_err_d = 1'b0;
          fail_stage_d  = '0;
          idx_d         = '0;
          cnt_d         = '0;
          busy_d        = 1'b1;
          state_d       = ST_ASSERT;
        end
      end

      default: begin
        state_d       = ST_ASSERT;
        cnt_d         = '0;
        idx_d         = '0;
        stage_reset_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk_25 or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_reset_q <= '1;
      all_up_q      <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
      fail_stage_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_reset_q <= stage_reset_d;
      all_up_q      <= all_up_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      fail_stage_q  <= fail_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign all_up      = all_up_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign fail_stage  = fail_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected stage_reset transitions (edge, value) are
// queued with the stimulus and matched by a monitor as the outputs change.
module tb_reset_sequencer;

  logic       clk_25 = 1'b0;
  logic       sys_reset_n;
  logic       soft_req;
  logic [3:0] stage_ready;
  logic [3:0] stage_reset;
  logic       all_up;
  logic       busy;
  logic       timeout_err;
  logic [1:0] fail_stage;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0] prev_sr = 4'hF;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;
  exp_t exp_q[$];

  reset_sequencer #(
    .NUM_STAGES   (4),
    .STAGE_DELAY  (16),
    .READY_TIMEOUT(255),
    .CNT_W        (8)
  ) dut (
    .clk_25     (clk_25),
    .sys_reset_n(sys_reset_n),
    .soft_req   (soft_req),
    .stage_ready(stage_ready),
    .stage_reset(stage_reset),
    .all_up     (all_up),
    .busy       (busy),
    .timeout_err(timeout_err),
    .fail_stage (fail_stage)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Standard release pattern relative to the edge where ASSERT starts counting.
  task automatic push_seq(input int base, input int stall1);
    push(base + 16, 4'hE);
    push(base + 33, 4'hC);
    push(base + 50 + stall1, 4'h8);
    push(base + 67 + stall1, 4'h0);
  endtask

  task automatic wait_until(input int n);
    for (int k = 0; k < 2000 && cyc < n; k++) begin
      @(posedge clk_25);
      #2;
    end
    if (cyc < n) check("wait_bound", cyc, n);
  endtask

  task automatic pulse_soft(input int at);
    wait_until(at);
    soft_req = 1'b1;
    @(posedge clk_25);
    #2;
    soft_req = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk_25);
    sys_reset_n = 1'b1;
  endtask

  always @(posedge clk_25) begin
    #1;
    if (sys_reset_n) begin
      cyc++;
      if (stage_reset !== prev_sr) begin
        if (exp_q.size() == 0) begin
          check("sr_unexpected", int'(stage_reset), int'(prev_sr));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sr_edge", cyc, e.cyc);
          check("sr_val", int'(stage_reset), int'(e.val));
        end
      end
    end else begin
      cyc = 0;
    end
    prev_sr = stage_reset;
  end

  initial begin
    sys_reset_n = 1'b0;
    soft_req    = 1'b0;
    stage_ready = 4'hF;
    repeat (3) @(posedge clk_25);
    #2;
    check("rst_sr", int'(stage_reset), 15);
    check("rst_all_up", int'(all_up), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_terr", int'(timeout_err), 0);
    check("rst_fstage", int'(fail_stage), 0);

    // Nominal sequence, with ignored soft_req pulses in ASSERT/WAIT_RDY/GAP
    push_seq(0, 0);
    release_reset();
    pulse_soft(5);
    pulse_soft(16);
    pulse_soft(25);
    wait_until(67);
    check("t1_all_up_pre", int'(all_up), 0);
    check("t1_busy_pre", int'(busy), 1);
    wait_until(68);
    check("t1_all_up", int'(all_up), 1);
    check("t1_busy", int'(busy), 0);
    check("t1_terr", int'(timeout_err), 0);

    // Soft re-sequence from RUN
    push(71, 4'h8);
    push(72, 4'hC);
    push(73, 4'hE);
    push(74, 4'hF);
    push_seq(74, 0);
    pulse_soft(70);
    check("t4_all_up_drop", int'(all_up), 0);
    check("t4_busy", int'(busy), 1);
    wait_until(142);
    check("t4_all_up", int'(all_up), 1);

    // Async reset in GAP after stage 1
    push(146, 4'h8);
    push(147, 4'hC);
    push(148, 4'hE);
    push(149, 4'hF);
    push(165, 4'hE);
    push(182, 4'hC);
    pulse_soft(145);
    wait_until(190);
    sys_reset_n = 1'b0;
    #5;
    check("t5_sr", int'(stage_reset), 15);
    check("t5_all_up", int'(all_up), 0);
    check("t5_terr", int'(timeout_err), 0);
    check("t5_q_drain", exp_q.size(), 0);

    // Late ready on stage 1
    stage_ready = 4'b1101;
    repeat (2) @(posedge clk_25);
    push_seq(0, 39);
    release_reset();
    wait_until(72);
    stage_ready = 4'hF;
    wait_until(107);
    check("t2_all_up", int'(all_up), 1);
    check("t2_terr", int'(timeout_err), 0);

    // Stage 2 never ready: timeout fault, then soft recovery
    sys_reset_n = 1'b0;
    stage_ready = 4'b1011;
    repeat (2) @(posedge clk_25);
    push(16, 4'hE);
    push(33, 4'hC);
    push(50, 4'h8);
    push(305, 4'hF);
    push_seq(311, 0);
    release_reset();
    wait_until(304);
    check("t3_terr_pre", int'(timeout_err), 0);
    check("t3_busy_pre", int'(busy), 1);
    wait_until(305);
    check("t3_terr", int'(timeout_err), 1);
    check("t3_fstage", int'(fail_stage), 2);
    check("t3_busy", int'(busy), 0);
    check("t3_all_up", int'(all_up), 0);
    stage_ready = 4'hF;
    pulse_soft(310);
    check("t3_terr_clr", int'(timeout_err), 0);
    check("t3_fstage_clr", int'(fail_stage), 0);
    check("t3_busy_rs", int'(busy), 1);
    wait_until(379);
    check("t3_all_up_end", int'(all_up), 1);
    check("q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
